// File: rtl/spike_count_classifier.sv
// spike_count_classifier
//   Decision stage behind a spiking network. Counts each output neuron's
//   spikes over a programmable window of enabled cycles, then walks the
//   counts one neuron per cycle to find the arg-max. The result is held
//   until the readout logic accepts it.
//
// Ports
//   i_clk            system clock (rising edge)
//   i_reset          asynchronous active-high reset; clears all state
//   i_enable         spikes are sampled only while high
//   i_start          begins a window; honoured only in IDLE
//   i_window_len     enabled cycles to observe (0 behaves as 1)
//   i_spikes         one spike bit per output neuron
//   o_busy           high whenever not IDLE
//   o_counts         neuron i at [i*CNT_BITS +: CNT_BITS]
//   o_winner         index of the highest count (lowest index on a tie)
//   o_tie            another neuron equals the maximum
//   o_result_valid   counts / winner / tie are final
//   i_result_ready   consumer accepts the result
module spike_count_classifier #(
  parameter int N        = 2,
  parameter int CNT_BITS = 8,
  parameter int WIN_BITS = 8,
  parameter int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_start,
  input  logic [WIN_BITS-1:0]   i_window_len,
  input  logic [N-1:0]          i_spikes,
  output logic                  o_busy,
  output logic [N*CNT_BITS-1:0] o_counts,
  output logic [IDX_W-1:0]      o_winner,
  output logic                  o_tie,
  output logic                  o_result_valid,
  input  logic                  i_result_ready
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_COMPARE, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [WIN_BITS-1:0]   r_remaining;
  logic [CNT_BITS-1:0]   r_counts [N];
  logic [CNT_BITS-1:0]   r_best;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_winner;
  logic                  r_tie;
  logic                  w_last_idx;
  logic                  w_last_sample;
  logic [CNT_BITS-1:0]   w_cur;

  // Saturating increment: a full counter stays full instead of wrapping.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] cnt,
                                                  input logic                spike);
    if (spike && (cnt != {CNT_BITS{1'b1}}))
      return cnt + CNT_BITS'(1);
    return cnt;
  endfunction

  assign w_last_idx    = (r_idx == IDX_W'(N - 1));
  assign w_last_sample = i_enable && (r_remaining == WIN_BITS'(1));
  assign w_cur         = r_counts[r_idx];

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start)        w_next = S_COUNT;
      S_COUNT:   if (w_last_sample)  w_next = S_COMPARE;
      S_COMPARE: if (w_last_idx)     w_next = S_DONE;
      S_DONE:    if (i_result_ready) w_next = S_IDLE;
      default:                       w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy         = (r_state != S_IDLE);
    o_result_valid = (r_state == S_DONE);
  end

  // Counters, window length and the sequential arg-max scan
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N; i++) r_counts[i] <= '0;
      r_remaining <= '0;
      r_best      <= '0;
      r_idx       <= '0;
      r_winner    <= '0;
      r_tie       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            for (int i = 0; i < N; i++) r_counts[i] <= '0;
            r_remaining <= (i_window_len == '0) ? WIN_BITS'(1) : i_window_len;
            r_idx       <= '0;
          end
        end
        S_COUNT: begin
          if (i_enable) begin
            for (int i = 0; i < N; i++) r_counts[i] <= sat_inc(r_counts[i], i_spikes[i]);
            r_remaining <= r_remaining - WIN_BITS'(1);
          end
        end
        S_COMPARE: begin
          if (r_idx == '0) begin
            r_best   <= w_cur;
            r_winner <= '0;
            r_tie    <= 1'b0;
          end else if (w_cur > r_best) begin
            r_best   <= w_cur;
            r_winner <= r_idx;
            r_tie    <= 1'b0;
          end else if (w_cur == r_best) begin
            // Keep the earlier (lower) index as winner, just flag the tie.
            r_tie    <= 1'b1;
          end
          if (!w_last_idx) r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_counts
    assign o_counts[g*CNT_BITS +: CNT_BITS] = r_counts[g];
  end

  assign o_winner = r_winner;
  assign o_tie    = r_tie;

endmodule

// File: tb/tb_spike_count_classifier.sv
module tb_spike_count_classifier;

  localparam int N        = 2;
  localparam int CNT_BITS = 4;
  localparam int WIN_BITS = 8;
  localparam int IDX_W    = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  enable;
  logic                  start;
  logic [WIN_BITS-1:0]   window_len;
  logic [N-1:0]          spikes;
  logic                  busy;
  logic [N*CNT_BITS-1:0] counts;
  logic [IDX_W-1:0]      winner;
  logic                  tie;
  logic                  result_valid;
  logic                  result_ready;

  int checks = 0;
  int errors = 0;

  spike_count_classifier #(
    .N(N), .CNT_BITS(CNT_BITS), .WIN_BITS(WIN_BITS)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_enable(enable),
    .i_start(start),
    .i_window_len(window_len),
    .i_spikes(spikes),
    .o_busy(busy),
    .o_counts(counts),
    .o_winner(winner),
    .o_tie(tie),
    .o_result_valid(result_valid),
    .i_result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_BITS-1:0] cnt(input int i);
    return counts[i*CNT_BITS +: CNT_BITS];
  endfunction

  // Pulse start for the edge E0; returns 1 unit after E0.
  task automatic start_win(input logic [WIN_BITS-1:0] wl);
    window_len = wl;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic accept();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    start        = 1'b0;
    window_len   = '0;
    spikes       = '0;
    result_ready = 1'b0;
    steps(2);

    // Reset values
    chk("rst_counts", counts, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_winner", winner, 0);
    chk("rst_tie", tie, 0);
    reset = 1'b0;
    step();

    // Reset in the middle of a window discards partial counts at once
    enable = 1'b1;
    spikes = 2'b01;
    start_win(8'd10);
    chk("midrst_busy_before", busy, 1);
    steps(3);
    chk("midrst_cnt0_before", cnt(0), 3);
    #2 reset = 1'b1;
    #1;
    chk("midrst_counts", counts, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", result_valid, 0);
    #1 reset = 1'b0;
    step();
    chk("midrst_idle_after", busy, 0);

    // Basic window: 5 samples of neuron 0
    spikes = 2'b01;
    start_win(8'd5);
    chk("basic_busy", busy, 1);
    steps(4);
    chk("basic_cnt0_4", cnt(0), 4);
    step();                         // Es
    chk("basic_valid_es", result_valid, 0);
    step();                         // Es+1
    chk("basic_valid_es1", result_valid, 0);
    step();                         // Es+2
    chk("basic_valid_es2", result_valid, 1);
    chk("basic_cnt0", cnt(0), 5);
    chk("basic_cnt1", cnt(1), 0);
    chk("basic_winner", winner, 0);
    chk("basic_tie", tie, 0);
    accept();
    chk("basic_acc_valid", result_valid, 0);
    chk("basic_acc_busy", busy, 0);

    // Gated enable: only every other cycle is counted
    spikes = 2'b10;
    start_win(8'd4);
    for (int k = 0; k < 8; k++) begin
      enable = (k % 2 == 0);
      step();
    end
    enable = 1'b0;
    chk("gated_cnt1", cnt(1), 4);
    chk("gated_valid_early", result_valid, 0);
    step();
    chk("gated_valid", result_valid, 1);
    chk("gated_cnt0", cnt(0), 0);
    chk("gated_winner", winner, 1);
    chk("gated_tie", tie, 0);
    accept();

    // Enable held low in COUNT: block waits with busy high
    spikes = 2'b11;
    start_win(8'd1);
    steps(6);
    chk("stall_busy", busy, 1);
    chk("stall_valid", result_valid, 0);
    chk("stall_counts", counts, 0);
    // Zero window length behaves as a single-cycle window (no spikes)
    reset = 1'b1;
    #1 reset = 1'b0;
    enable = 1'b1;
    spikes = 2'b00;
    start_win(8'd0);
    step();                         // Es
    chk("zero_busy_es", busy, 1);
    step();
    chk("zero_valid_es1", result_valid, 0);
    step();
    chk("zero_valid", result_valid, 1);
    chk("zero_counts", counts, 0);
    chk("zero_winner", winner, 0);
    chk("zero_tie", tie, 1);
    accept();

    // Tie: both neurons fire 3 times; ready held high early has no effect
    spikes       = 2'b11;
    result_ready = 1'b1;
    start_win(8'd3);
    steps(4);                       // Es+1
    chk("tie_busy_rdy", busy, 1);
    chk("tie_valid_es1", result_valid, 0);
    step();                         // Es+2
    chk("tie_valid", result_valid, 1);
    chk("tie_cnt0", cnt(0), 3);
    chk("tie_cnt1", cnt(1), 3);
    chk("tie_winner", winner, 0);
    chk("tie_tie", tie, 1);
    step();
    result_ready = 1'b0;
    chk("tie_acc_busy", busy, 0);

    // Saturation at 2^CNT_BITS-1
    spikes = 2'b10;
    start_win(8'd20);
    steps(22);
    chk("sat_valid", result_valid, 1);
    chk("sat_cnt1", cnt(1), 15);
    chk("sat_cnt0", cnt(0), 0);
    chk("sat_winner", winner, 1);
    chk("sat_tie", tie, 0);

    // Backpressure: result held, start in DONE ignored
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      start = 1'b0;
      if (k == 4 || k == 9) begin
        chk("bp_valid", result_valid, 1);
        chk("bp_cnt1", cnt(1), 15);
        chk("bp_winner", winner, 1);
      end
    end
    // Start asserted on the acceptance edge is ignored
    result_ready = 1'b1;
    start        = 1'b1;
    step();
    result_ready = 1'b0;
    start        = 1'b0;
    chk("bp_acc_valid", result_valid, 0);
    chk("bp_acc_busy", busy, 0);
    step();
    chk("bp_start_ignored", busy, 0);
    chk("bp_idle_hold_cnt1", cnt(1), 15);
    chk("bp_idle_hold_winner", winner, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_count_classifier.md
# spike_count_classifier

Output decision stage placed directly downstream of the two-layer spiking network. It counts the output-layer spikes of each of the N neurons over a programmable observation window, then runs a sequential arg-max to select the winning class. It presents the per-neuron counts, winner index and tie flag through a valid/ready handshake to the readout logic.

## Interface
- N, 2, number of output neurons (width of `spikes`)
- CNT_BITS, 8, width of each per-neuron spike counter
- WIN_BITS, 8, width of the window-length input
- IDX_W, max(1, $clog2(N)), width of the winner index (derived; do not override)

- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  network enable; spikes are sampled only on cycles where it is high
- start  in  1  single-cycle request to begin a window; honoured only in IDLE
- window_len  in  WIN_BITS  number of enabled cycles to observe; 0 is treated as 1; captured at start
- spikes  in  N  output spikes of the network's last layer
- busy  out  1  high whenever the state is not IDLE
- counts  out  N*CNT_BITS  per-neuron spike counts; neuron i at bits [i*CNT_BITS +: CNT_BITS]
- winner  out  IDX_W  index of the neuron with the highest count
- tie  out  1  another neuron equals the maximum count
- result_valid  out  1  counts, winner and tie are final
- result_ready  in  1  consumer accepts the result

## Operation
- FSM states: IDLE, COUNT, COMPARE, DONE. Reset places the FSM in IDLE and clears every register. Reset values: counts=0, winner=0, tie=0, result_valid=0, busy=0.
- IDLE, start=1: clear all counts, load remaining = (window_len==0 ? 1 : window_len), go to COUNT. start is ignored in every other state.
- COUNT, on each edge where enable=1:
  - counts[i] += spikes[i] for every i. Each count saturates at 2^CNT_BITS-1 and never wraps.
  - Decrement remaining. If remaining was 1, go to COMPARE with idx=0.
  - Edges where enable=0 change nothing.
- COMPARE: one neuron per edge.
  - idx=0: best=counts[0], winner=0, tie=0.
  - idx>0, counts[idx] > best: best=counts[idx], winner=idx, tie=0.
  - idx>0, counts[idx] == best: tie=1. Ties resolve to the lowest index.
  - idx<N-1: increment idx. idx==N-1: go to DONE.
- DONE: result_valid=1. counts, winner and tie hold stable. When result_valid && result_ready on an edge, go to IDLE.
- counts, winner and tie keep their last values in IDLE until the next start clears counts.
- All counts zero yields winner=0 and tie=1 (for N>1).

## Timing
- start sampled at edge E0 gives busy=1 after E0. The first spike sample occurs at edge E1.
- The final sample edge Es is the edge that consumes the last enabled cycle. Exactly window_len enabled cycles are counted, including any sampled at Es.
- COMPARE occupies N edges. result_valid rises after edge Es+N.
- Handshake: result_valid is held until accepted. Acceptance at edge Ea gives result_valid=0 and busy=0 after Ea.
- Earliest next start is sampled at edge Ea+1. A start asserted at Ea is ignored.
- result_ready asserted while result_valid=0 has no effect.
- Asynchronous reset mid-window or mid-handshake:
  - Outputs go to reset values immediately.
  - The FSM is in IDLE when reset deasserts.
  - Partial counts are discarded.
- With enable held 0 in COUNT, the block waits indefinitely and busy stays 1.

## Test plan
- **Reset values:** assert reset mid-COUNT with counts=3 → counts=0, busy=0, result_valid=0 immediately. After release, a start begins a fresh window.
- **Basic window:** N=2, window_len=5, enable=1, spikes=2'b01 every cycle → counts[0]=5, counts[1]=0, winner=0, tie=0. result_valid high exactly 2 edges after the 5th sample edge.
- **Gated enable:** window_len=4, enable toggling 1,0,1,0,..., spikes[1]=1 always → counts[1]=4 after 8 COUNT cycles, winner=1.
- **Tie and zero:** spikes[0] and spikes[1] both fire 3 times → winner=0, tie=1. Separately, window_len=0 with no spikes → a 1-cycle window, counts=0, winner=0, tie=1.
- **Saturation:** CNT_BITS=4, window_len=20, spikes=2'b10 → counts[1]=15 (no wrap), winner=1.
- **Handshake backpressure:** hold result_ready=0 for 10 cycles → result_valid and outputs stay stable, and a start pulse during DONE is ignored. Raising result_ready → IDLE next cycle.
